// File: rtl/axi4_lite_ram.sv
// -----------------------------------------------------------------------------
// axi4_lite_ram
//
// AXI4-Lite subordinate backed by a word-organised register array. The read
// and write channels are independent and each allows one outstanding
// transaction. It is used as data/scratch memory and as the default endpoint
// of interconnect benches.
//
// Parameters
//   ADDR_WIDTH  byte-address width of i_araddr / i_awaddr
//   DATA_WIDTH  data width, a power-of-two multiple of 8
//   DEPTH       number of DATA_WIDTH words, a power of two
//
// Ports
//   i_aclk      bus clock, all logic on the rising edge
//   i_aresetn   synchronous active-low reset
//   Read address : i_arvalid, o_arready, i_araddr
//   Read data    : o_rvalid, i_rready, o_rdata
//   Write address: i_awvalid, o_awready, i_awaddr
//   Write data   : i_wvalid, o_wready, i_wdata
//   Write resp   : o_bvalid, i_bready, o_bresp (3'b000 OKAY, 3'b011 DECERR)
//
// Every output is driven straight from a register, so no valid depends
// combinationally on a ready. Reset clears the handshake state and the
// outputs but leaves the memory contents alone.
// -----------------------------------------------------------------------------
module axi4_lite_ram #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 256
) (
   input  logic                  i_aclk,
   input  logic                  i_aresetn,
   // read address channel
   input  logic                  i_arvalid,
   output logic                  o_arready,
   input  logic [ADDR_WIDTH-1:0] i_araddr,
   // read data channel
   output logic                  o_rvalid,
   input  logic                  i_rready,
   output logic [DATA_WIDTH-1:0] o_rdata,
   // write address channel
   input  logic                  i_awvalid,
   output logic                  o_awready,
   input  logic [ADDR_WIDTH-1:0] i_awaddr,
   // write data channel
   input  logic                  i_wvalid,
   output logic                  o_wready,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   // write response channel
   output logic                  o_bvalid,
   input  logic                  i_bready,
   output logic [2:0]            o_bresp
);

   // Byte-offset bits dropped from the address, and index bits kept.
   localparam int OFF_W = $clog2(DATA_WIDTH / 8);
   localparam int IDX_W = $clog2(DEPTH);

   localparam logic [2:0] RESP_OKAY   = 3'b000;
   localparam logic [2:0] RESP_DECERR = 3'b011;

   typedef enum logic {
      R_IDLE,
      R_RESP
   } r_state_t;

   // --------------------------------------------------------------------------
   // Address decode. The address is first turned into a word number; the low
   // IDX_W bits of that select the word and anything above them means the
   // access falls outside the array.
   // --------------------------------------------------------------------------
   logic [ADDR_WIDTH-1:0] w_ar_word;
   logic [IDX_W-1:0]      w_ar_idx;
   logic                  w_ar_oor;
   logic [ADDR_WIDTH-1:0] w_aw_word;
   logic [IDX_W-1:0]      w_aw_idx;
   logic                  w_aw_oor;

   assign w_ar_word = i_araddr >> OFF_W;
   assign w_ar_idx  = w_ar_word[IDX_W-1:0];
   assign w_ar_oor  = (w_ar_word >> IDX_W) != '0;

   assign w_aw_word = i_awaddr >> OFF_W;
   assign w_aw_idx  = w_aw_word[IDX_W-1:0];
   assign w_aw_oor  = (w_aw_word >> IDX_W) != '0;

   // --------------------------------------------------------------------------
   // Storage
   // --------------------------------------------------------------------------
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   // --------------------------------------------------------------------------
   // Write-side state
   // --------------------------------------------------------------------------
   logic                  r_aw_held;   // an address has been accepted
   logic [IDX_W-1:0]      r_aw_idx;
   logic                  r_aw_oor;
   logic                  r_w_held;    // a data beat has been accepted
   logic [DATA_WIDTH-1:0] r_wdata;
   logic                  r_awready;
   logic                  r_wready;
   logic                  r_bvalid;
   logic [2:0]            r_bresp;
   logic                  w_commit;

   // Both halves are present and no response is outstanding: this edge
   // performs the memory write and raises the response.
   assign w_commit = r_aw_held && r_w_held && !r_bvalid;

   always_ff @(posedge i_aclk) begin
      if (!i_aresetn) begin
         r_aw_held <= 1'b0;
         r_aw_idx  <= '0;
         r_aw_oor  <= 1'b0;
         r_w_held  <= 1'b0;
         r_wdata   <= '0;
         r_awready <= 1'b0;
         r_wready  <= 1'b0;
         r_bvalid  <= 1'b0;
         r_bresp   <= RESP_OKAY;
      end else if (r_bvalid) begin
         // Response outstanding: both readys are already low and stay low
         // until the response is taken, then everything frees up together.
         if (i_bready) begin
            r_bvalid  <= 1'b0;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
         end
      end else if (w_commit) begin
         r_bvalid <= 1'b1;
         r_bresp  <= r_aw_oor ? RESP_DECERR : RESP_OKAY;
      end else begin
         // AW and W are captured independently, in any order.
         if (r_awready && i_awvalid) begin
            r_aw_held <= 1'b1;
            r_aw_idx  <= w_aw_idx;
            r_aw_oor  <= w_aw_oor;
            r_awready <= 1'b0;
         end else begin
            r_awready <= !r_aw_held;
         end

         if (r_wready && i_wvalid) begin
            r_w_held <= 1'b1;
            r_wdata  <= i_wdata;
            r_wready <= 1'b0;
         end else begin
            r_wready <= !r_w_held;
         end
      end
   end

   // NOTE: the memory array has no reset branch on purpose: contents must
   // survive a bus reset, and leaving it out keeps the array mappable onto
   // plain storage instead of thousands of resettable flops. The write is
   // still gated by i_aresetn so a reset edge never commits a dropped write.
   always_ff @(posedge i_aclk) begin
      if (i_aresetn && w_commit && !r_aw_oor) begin
         r_mem[r_aw_idx] <= r_wdata;
      end
   end

   // --------------------------------------------------------------------------
   // Read FSM
   // --------------------------------------------------------------------------
   r_state_t              r_state;
   logic                  r_arready;
   logic                  r_rvalid;
   logic [DATA_WIDTH-1:0] r_rdata;

   // NOTE: all state here uses non-blocking assignment. Besides avoiding
   // simulation races, it is what makes a read that lands on the same edge
   // as a memory write return the old word: r_mem is sampled before the
   // write in the block above takes effect.
   always_ff @(posedge i_aclk) begin
      if (!i_aresetn) begin
         r_state   <= R_IDLE;
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rdata   <= '0;
      end else begin
         case (r_state)
            R_IDLE: begin
               if (r_arready && i_arvalid) begin
                  r_rdata   <= w_ar_oor ? '0 : r_mem[w_ar_idx];
                  r_arready <= 1'b0;
                  r_rvalid  <= 1'b1;
                  r_state   <= R_RESP;
               end else begin
                  // Also the path that raises arready after reset.
                  r_arready <= 1'b1;
               end
            end
            R_RESP: begin
               // rdata is untouched here, so it holds until taken.
               if (i_rready) begin
                  r_rvalid  <= 1'b0;
                  r_arready <= 1'b1;
                  r_state   <= R_IDLE;
               end
            end
            default: begin
               r_state <= R_IDLE;
            end
         endcase
      end
   end

   // --------------------------------------------------------------------------
   // Outputs
   // --------------------------------------------------------------------------
   assign o_arready = r_arready;
   assign o_rvalid  = r_rvalid;
   assign o_rdata   = r_rdata;
   assign o_awready = r_awready;
   assign o_wready  = r_wready;
   assign o_bvalid  = r_bvalid;
   assign o_bresp   = r_bresp;

endmodule

// File: tb/tb_axi4_lite_ram.sv
// -----------------------------------------------------------------------------
// tb_axi4_lite_ram
//
// Self-checking bench for axi4_lite_ram (32-bit address/data, 256 words).
// A transaction-level reference model tracks what the bus must show: which
// channels may accept, which responses are outstanding, and the memory
// contents as plain arrays. A compare process checks every output against it
// on each falling edge. Directed scenarios add literal expectations, then a
// randomized phase mixes reads, writes and concurrent traffic.
// -----------------------------------------------------------------------------
module tb_axi4_lite_ram;

   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int DEPTH = 256;

   logic          aclk = 1'b0;
   logic          aresetn;
   logic          arvalid, arready, rvalid, rready;
   logic [AW-1:0] araddr;
   logic [DW-1:0] rdata;
   logic          awvalid, awready, wvalid, wready, bvalid, bready;
   logic [AW-1:0] awaddr;
   logic [DW-1:0] wdata;
   logic [2:0]    bresp;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 aclk = ~aclk;

   axi4_lite_ram #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW),
      .DEPTH     (DEPTH)
   ) dut (
      .i_aclk   (aclk),
      .i_aresetn(aresetn),
      .i_arvalid(arvalid),
      .o_arready(arready),
      .i_araddr (araddr),
      .o_rvalid (rvalid),
      .i_rready (rready),
      .o_rdata  (rdata),
      .i_awvalid(awvalid),
      .o_awready(awready),
      .i_awaddr (awaddr),
      .i_wvalid (wvalid),
      .o_wready (wready),
      .i_wdata  (wdata),
      .o_bvalid (bvalid),
      .i_bready (bready),
      .o_bresp  (bresp)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // --------------------------------------------------------------------------
   // Reference model (transaction level, plain arrays)
   // --------------------------------------------------------------------------
   function automatic bit out_of_range(input logic [31:0] a);
      return (a / 4) >= DEPTH;
   endfunction

   function automatic int word_of(input logic [31:0] a);
      return int'((a / 4) % DEPTH);
   endfunction

   logic [31:0] m_mem   [DEPTH];
   bit          m_known [DEPTH];
   bit          m_live = 1'b0;   // model has seen its first edge
   bit          m_ready_en;      // bus has left reset for at least one edge
   bit          m_rbusy;         // read response outstanding
   logic [31:0] m_rdata;
   bit          m_rknown;        // m_rdata comes from a word the bench wrote
   bit          m_rfresh;        // no read since reset, rdata must still be 0
   bit          m_aw_have;
   logic [31:0] m_aw_addr;
   bit          m_w_have;
   logic [31:0] m_w_data;
   bit          m_bpend;
   logic [2:0]  m_bresp;
   bit          m_bfresh;

   wire ar_hs  = m_ready_en && !m_rbusy && arvalid;
   wire aw_hs  = m_ready_en && !m_aw_have && !m_bpend && awvalid;
   wire w_hs   = m_ready_en && !m_w_have && !m_bpend && wvalid;
   wire commit = m_aw_have && m_w_have && !m_bpend;

   always @(posedge aclk) begin
      m_live <= 1'b1;
      if (!aresetn) begin
         m_ready_en <= 1'b0;
         m_rbusy    <= 1'b0;
         m_rdata    <= '0;
         m_rknown   <= 1'b1;
         m_rfresh   <= 1'b1;
         m_aw_have  <= 1'b0;
         m_w_have   <= 1'b0;
         m_bpend    <= 1'b0;
         m_bresp    <= 3'b000;
         m_bfresh   <= 1'b1;
      end else begin
         m_ready_en <= 1'b1;
         // Reads see memory as it was before any write on this same edge.
         if (ar_hs) begin
            m_rbusy  <= 1'b1;
            m_rfresh <= 1'b0;
            m_rdata  <= out_of_range(araddr) ? 32'h0 : m_mem[word_of(araddr)];
            m_rknown <= out_of_range(araddr) ? 1'b1 : m_known[word_of(araddr)];
         end else if (m_rbusy && rready) begin
            m_rbusy <= 1'b0;
         end
         if (commit) begin
            m_bpend  <= 1'b1;
            m_bfresh <= 1'b0;
            if (out_of_range(m_aw_addr)) begin
               m_bresp <= 3'b011;
            end else begin
               m_bresp                    <= 3'b000;
               m_mem[word_of(m_aw_addr)]   <= m_w_data;
               m_known[word_of(m_aw_addr)] <= 1'b1;
            end
         end
         if (m_bpend && bready) begin
            m_bpend   <= 1'b0;
            m_aw_have <= 1'b0;
            m_w_have  <= 1'b0;
         end
         if (aw_hs) begin
            m_aw_have <= 1'b1;
            m_aw_addr <= awaddr;
         end
         if (w_hs) begin
            m_w_have <= 1'b1;
            m_w_data <= wdata;
         end
      end
   end

   // --------------------------------------------------------------------------
   // Cycle-by-cycle compare against the model
   // --------------------------------------------------------------------------
   always @(negedge aclk) begin
      if (m_live) begin
         check("arready", 32'(arready), 32'(m_ready_en && !m_rbusy));
         check("rvalid",  32'(rvalid),  32'(m_rbusy));
         if ((m_rbusy && m_rknown) || m_rfresh)
            check("rdata", rdata, m_rdata);
         check("awready", 32'(awready), 32'(m_ready_en && !m_aw_have && !m_bpend));
         check("wready",  32'(wready),  32'(m_ready_en && !m_w_have && !m_bpend));
         check("bvalid",  32'(bvalid),  32'(m_bpend));
         if (m_bpend || m_bfresh)
            check("bresp", 32'(bresp), 32'(m_bresp));
      end
   end

   // --------------------------------------------------------------------------
   // Bus drivers. Each starts and ends on a falling edge. Delays count
   // cycles from the start of the task.
   // --------------------------------------------------------------------------
   task automatic write_txn(input logic [31:0] addr, input logic [31:0] data,
                            input int aw_dly, input int w_dly, input int b_dly,
                            output logic [2:0] resp);
      bit aw_done = 1'b0;
      bit w_done  = 1'b0;
      bit b_done  = 1'b0;
      bit aw_now, w_now, b_now;
      int c = 0;
      resp = 3'b111;
      while (!b_done && c < 100) begin
         awvalid = !aw_done && (c >= aw_dly);
         awaddr  = addr;
         wvalid  = !w_done && (c >= w_dly);
         wdata   = data;
         bready  = (c >= b_dly);
         aw_now  = awvalid && awready;
         w_now   = wvalid && wready;
         b_now   = bready && bvalid;
         if (b_now) resp = bresp;
         @(negedge aclk);
         aw_done |= aw_now;
         w_done  |= w_now;
         b_done  |= b_now;
         c++;
      end
      awvalid = 1'b0;
      wvalid  = 1'b0;
      bready  = 1'b0;
      check("write_completed", 32'(b_done), 32'd1);
   endtask

   task automatic read_txn(input logic [31:0] addr, input int ar_dly, input int r_dly,
                           output logic [31:0] data);
      bit ar_done = 1'b0;
      bit r_done  = 1'b0;
      bit ar_now, r_now;
      int c = 0;
      data = 32'hxxxx_xxxx;
      while (!r_done && c < 100) begin
         arvalid = !ar_done && (c >= ar_dly);
         araddr  = addr;
         rready  = (c >= r_dly);
         ar_now  = arvalid && arready;
         r_now   = rready && rvalid;
         if (r_now) data = rdata;
         @(negedge aclk);
         ar_done |= ar_now;
         r_done  |= r_now;
         c++;
      end
      arvalid = 1'b0;
      rready  = 1'b0;
      check("read_completed", 32'(r_done), 32'd1);
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      if ($urandom_range(0, 9) == 0)
         a = ($urandom_range(1, 255) << 10) | $urandom_range(0, 1023);
      else
         a = ($urandom_range(0, 15) * 4) + $urandom_range(0, 3);
      return a;
   endfunction

   // --------------------------------------------------------------------------
   // Stimulus
   // --------------------------------------------------------------------------
   initial begin
      logic [31:0] d, d2;
      logic [2:0]  r;

      aresetn = 1'b0;
      arvalid = 1'b1;
      awvalid = 1'b1;
      araddr  = '0;
      awaddr  = '0;
      wvalid  = 1'b0;
      wdata   = '0;
      rready  = 1'b0;
      bready  = 1'b0;

      // Reset held for three edges with valids asserted.
      repeat (3) @(negedge aclk);
      check("rst_arready", 32'(arready), 32'd0);
      check("rst_awready", 32'(awready), 32'd0);
      check("rst_wready",  32'(wready),  32'd0);
      check("rst_rvalid",  32'(rvalid),  32'd0);
      check("rst_bvalid",  32'(bvalid),  32'd0);
      check("rst_rdata",   rdata,        32'h0);
      check("rst_bresp",   32'(bresp),   32'd0);
      arvalid = 1'b0;
      awvalid = 1'b0;
      aresetn = 1'b1;
      @(negedge aclk);
      check("rel_arready", 32'(arready), 32'd1);
      check("rel_awready", 32'(awready), 32'd1);
      check("rel_wready",  32'(wready),  32'd1);

      // Basic write then read.
      write_txn(32'h10, 32'hDEAD_BEEF, 0, 0, 0, r);
      check("basic_bresp", 32'(r), 32'd0);
      read_txn(32'h10, 0, 0, d);
      check("basic_rdata", d, 32'hDEAD_BEEF);

      // W three cycles ahead of AW, response left waiting four cycles.
      write_txn(32'h20, 32'h1234_5678, 3, 0, 9, r);
      check("order_bresp", 32'(r), 32'd0);
      read_txn(32'h20, 0, 0, d);
      check("order_rdata", d, 32'h1234_5678);

      // Read data held back for five cycles.
      read_txn(32'h10, 0, 6, d);
      check("bp_rdata", d, 32'hDEAD_BEEF);
      read_txn(32'h13, 0, 0, d);
      check("unaligned_rdata", d, 32'hDEAD_BEEF);

      // Decode error: first word above the array.
      write_txn(32'h0, 32'hCAFE_F00D, 0, 0, 0, r);
      write_txn(32'h400, 32'h5555_AAAA, 0, 0, 0, r);
      check("decerr_bresp", 32'(r), 32'd3);
      read_txn(32'h400, 0, 0, d);
      check("decerr_rdata", d, 32'h0);
      read_txn(32'h0, 0, 0, d);
      check("decerr_mem0", d, 32'hCAFE_F00D);

      // Read colliding with the memory-write edge returns the old word.
      write_txn(32'h30, 32'h1111_1111, 0, 0, 0, r);
      awvalid = 1'b1;
      awaddr  = 32'h30;
      wvalid  = 1'b1;
      wdata   = 32'hA5A5_A5A5;
      bready  = 1'b0;
      @(negedge aclk);
      awvalid = 1'b0;
      wvalid  = 1'b0;
      arvalid = 1'b1;
      araddr  = 32'h30;
      rready  = 1'b0;
      @(negedge aclk);
      arvalid = 1'b0;
      check("coll_rvalid", 32'(rvalid), 32'd1);
      check("coll_rdata",  rdata,       32'h1111_1111);
      check("coll_bvalid", 32'(bvalid), 32'd1);
      rready = 1'b1;
      @(negedge aclk);
      rready = 1'b0;

      // Reset while the response is still pending: it must vanish.
      aresetn = 1'b0;
      @(negedge aclk);
      check("midrst_bvalid", 32'(bvalid), 32'd0);
      aresetn = 1'b1;
      bready  = 1'b1;
      repeat (3) begin
         @(negedge aclk);
         check("midrst_no_resp", 32'(bvalid), 32'd0);
      end
      bready = 1'b0;
      read_txn(32'h30, 0, 0, d);
      check("midrst_mem", d, 32'hA5A5_A5A5);

      // Randomized traffic, including reads and writes in flight together.
      for (int t = 0; t < 200; t++) begin
         logic [31:0] wa, ra, wd;
         int mode;
         mode = $urandom_range(0, 2);
         wa   = rand_addr();
         ra   = rand_addr();
         wd   = $urandom();
         if (mode == 0) begin
            write_txn(wa, wd, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 5), r);
         end else if (mode == 1) begin
            read_txn(ra, $urandom_range(0, 3), $urandom_range(0, 5), d);
         end else begin
            fork
               write_txn(wa, wd, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 4), r);
               read_txn(ra, $urandom_range(0, 4), $urandom_range(0, 4), d2);
            join
         end
      end

      repeat (2) @(negedge aclk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
